// File: rtl/dekker_lock_server_pkg.sv
// dekker_lock_server_pkg: client state encoding shared by the lock server and the client-process models
package dekker_lock_server_pkg;
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_OWN  = 2'd2,
      S_REL  = 2'd3
   } state_t;
   function automatic logic holds_resource(input state_t s);
      return s == S_OWN || s == S_REL;
   endfunction
endpackage

// File: rtl/dekker_client_fsm.sv
// dekker_client_fsm: per-client Dekker state, saturating wait counter and hold counter
// Forced revocation after HOLD_LIMIT owned cycles is enabled by LOCK_REVOKE_EN.
module dekker_client_fsm
   import dekker_lock_server_pkg::*;
#(
   parameter int WAIT_W     = 3,
   parameter int HOLD_LIMIT = 5
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_req,
   input  logic              i_rel,
   input  logic              i_grant,
   output state_t            o_state,
   output logic [WAIT_W-1:0] o_wait_cnt,
   output logic              o_revoked
);
   localparam int HOLD_W = $clog2(HOLD_LIMIT + 1);
`ifdef LOCK_REVOKE_EN
   localparam bit REVOKE_EN = 1'b1;
`else
   localparam bit REVOKE_EN = 1'b0;
`endif
   state_t            r_state, w_next;
   logic [WAIT_W-1:0] r_wait;
   logic [HOLD_W-1:0] r_hold;
   logic              r_revoked, w_force;
   // the last owned cycle with rel low behaves as an implicit release
   assign w_force = REVOKE_EN && r_state == S_OWN && !i_rel && r_hold == HOLD_W'(HOLD_LIMIT - 1);
   always_ff @(posedge i_clock) begin
      if (i_reset) r_state <= S_IDLE;
      else r_state <= w_next;
   end
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_wait    <= '0;
         r_hold    <= '0;
         r_revoked <= 1'b0;
      end else begin
         r_wait    <= (w_next == S_REQ) ? (&r_wait ? r_wait : r_wait + 1'b1) : '0;
         r_hold    <= (REVOKE_EN && r_state == S_OWN && w_next == S_OWN) ? r_hold + 1'b1 : '0;
         r_revoked <= w_force;
      end
   end
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  w_next = i_req ? S_REQ : S_IDLE;
         S_REQ:   w_next = !i_req ? S_IDLE : i_grant ? S_OWN : S_REQ;
         S_OWN:   w_next = (i_rel || w_force) ? S_REL : S_OWN;
         S_REL:   w_next = S_IDLE;
      endcase
   end
   always_comb begin
      o_state    = r_state;
      o_wait_cnt = r_wait;
      o_revoked  = r_revoked;
   end
endmodule

// File: rtl/dekker_lock_server.sv
// dekker_lock_server: two-client Dekker lock responder with turn-bit fairness and mutual-exclusion assertion
// Optional forced revocation is compiled in with LOCK_REVOKE_EN.
module dekker_lock_server
   import dekker_lock_server_pkg::*;
#(
   parameter int WAIT_W     = 3,
   parameter int HOLD_LIMIT = 5
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic [1:0]        i_req,
   input  logic [1:0]        i_rel,
   output logic [1:0]        o_gnt,
   output logic              o_turn,
   output logic [WAIT_W-1:0] o_wait_cnt0,
   output logic [WAIT_W-1:0] o_wait_cnt1,
   output logic [1:0]        o_revoked
);
   state_t            w_state [2];
   logic [WAIT_W-1:0] w_wait  [2];
   logic [1:0]        w_cand, w_grant;
   logic              w_busy, w_prop, r_turn;
   genvar g;
   for (g = 0; g < 2; g++) begin : g_client
      dekker_client_fsm #(.WAIT_W(WAIT_W), .HOLD_LIMIT(HOLD_LIMIT)) u_fsm (
         .i_clock    (i_clock),
         .i_reset    (i_reset),
         .i_req      (i_req[g]),
         .i_rel      (i_rel[g]),
         .i_grant    (w_grant[g]),
         .o_state    (w_state[g]),
         .o_wait_cnt (w_wait[g]),
         .o_revoked  (o_revoked[g])
      );
      assign w_cand[g] = w_state[g] == S_REQ && i_req[g];
      assign o_gnt[g]  = w_state[g] == S_OWN;
   end
   assign w_busy = holds_resource(w_state[0]) || holds_resource(w_state[1]);
   // on contention the turn holder wins; a lone candidate wins regardless of turn
   assign w_grant[0] = !w_busy && w_cand[0] && (!w_cand[1] || !r_turn);
   assign w_grant[1] = !w_busy && w_cand[1] && (!w_cand[0] || r_turn);
   always_ff @(posedge i_clock) begin
      r_turn <= i_reset ? 1'b0 : w_state[0] == S_REL ? 1'b1 : w_state[1] == S_REL ? 1'b0 : r_turn;
   end
   assign o_turn      = r_turn;
   assign o_wait_cnt0 = w_wait[0];
   assign o_wait_cnt1 = w_wait[1];
   assign w_prop = !(o_gnt[0] && o_gnt[1]);
   a_mutex: assert property (@(posedge i_clock) disable iff (i_reset) w_prop);
endmodule

// File: tb/tb_dekker_lock_server.sv
// tb_dekker_lock_server: directed scenarios plus randomized run against an ownership-level reference model
module tb_dekker_lock_server;
   localparam int WAIT_W     = 3;
   localparam int HOLD_LIMIT = 5;
   localparam int WMAX       = (1 << WAIT_W) - 1;
`ifdef LOCK_REVOKE_EN
   localparam bit REV = 1'b1;
`else
   localparam bit REV = 1'b0;
`endif
   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [1:0]        req = 2'b00;
   logic [1:0]        rel = 2'b00;
   logic [1:0]        gnt, revoked;
   logic              turn;
   logic [WAIT_W-1:0] wc0, wc1;
   int checks   = 0;
   int failures = 0;
   // model: who owns, who is in the dead release cycle, who is waiting
   int         m_owner, m_dead, m_held;
   bit         m_turn;
   bit         m_pend [2];
   int         m_wait [2];
   logic [1:0] m_revk;

   dekker_lock_server #(.WAIT_W(WAIT_W), .HOLD_LIMIT(HOLD_LIMIT)) dut (
      .i_clock     (clk),
      .i_reset     (rst),
      .i_req       (req),
      .i_rel       (rel),
      .o_gnt       (gnt),
      .o_turn      (turn),
      .o_wait_cnt0 (wc0),
      .o_wait_cnt1 (wc1),
      .o_revoked   (revoked)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] exp_gnt();
      return m_owner == 0 ? 2'b01 : m_owner == 1 ? 2'b10 : 2'b00;
   endfunction

   task automatic model_edge(input logic [1:0] rq, input logic [1:0] rl, input logic rs);
      int         w, n_owner, n_dead, n_held;
      bit         n_turn, c0, c1, idle;
      bit         n_pend [2];
      logic [1:0] n_revk;
      if (rs) begin
         m_owner = -1; m_dead = -1; m_held = 0; m_turn = 1'b0;
         m_pend = '{1'b0, 1'b0}; m_wait = '{0, 0}; m_revk = 2'b00;
         return;
      end
      c0 = m_pend[0] && rq[0];
      c1 = m_pend[1] && rq[1];
      w = -1;
      if (m_owner < 0 && m_dead < 0) w = (c0 && c1) ? int'(m_turn) : c0 ? 0 : c1 ? 1 : -1;
      n_turn = (m_dead >= 0) ? (m_dead == 0) : m_turn;
      n_owner = m_owner; n_dead = -1; n_held = m_held; n_revk = 2'b00;
      if (m_owner >= 0) begin
         if (rl[m_owner]) begin
            n_dead = m_owner; n_owner = -1; n_held = 0;
         end else if (REV && m_held == HOLD_LIMIT) begin
            n_dead = m_owner; n_owner = -1; n_held = 0; n_revk[m_owner] = 1'b1;
         end else n_held = m_held + 1;
      end
      for (int i = 0; i < 2; i++) begin
         idle = m_owner != i && m_dead != i && !m_pend[i];
         if (w == i) begin
            n_pend[i] = 1'b0; n_owner = i; n_held = 1;
         end else if (m_pend[i] || idle) n_pend[i] = rq[i];
         else n_pend[i] = 1'b0;
         m_wait[i] = n_pend[i] ? ((m_wait[i] + 1 > WMAX) ? WMAX : m_wait[i] + 1) : 0;
      end
      m_owner = n_owner; m_dead = n_dead; m_held = n_held; m_turn = n_turn;
      m_pend = n_pend; m_revk = n_revk;
   endtask

   task automatic step(input logic [1:0] rq, input logic [1:0] rl);
      req = rq;
      rel = rl;
      @(posedge clk);
      model_edge(rq, rl, rst);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(2'b00, 2'b00);
      step(2'b00, 2'b00);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(2'b11, 2'b11);
      step(2'b11, 2'b11);
      checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
      checks++; if (turn !== 1'b0) begin failures++; $display("FAIL reset_turn got=%b exp=0", turn); end
      checks++; if (wc0 !== 3'd0) begin failures++; $display("FAIL reset_wc0 got=%0d exp=0", wc0); end
      checks++; if (wc1 !== 3'd0) begin failures++; $display("FAIL reset_wc1 got=%0d exp=0", wc1); end
      checks++; if (revoked !== 2'b00) begin failures++; $display("FAIL reset_revoked got=%b exp=00", revoked); end
      rst = 1'b0;
   endtask

   task automatic test_single();
      do_reset();
      step(2'b01, 2'b00);
      checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL single_gnt_t1 got=%b exp=00", gnt); end
      checks++; if (wc0 !== 3'd1) begin failures++; $display("FAIL single_wc0_t1 got=%0d exp=1", wc0); end
      step(2'b01, 2'b00);
      checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL single_gnt_t2 got=%b exp=01", gnt); end
      checks++; if (wc0 !== 3'd0) begin failures++; $display("FAIL single_wc0_t2 got=%0d exp=0", wc0); end
      checks++; if (turn !== 1'b0) begin failures++; $display("FAIL single_turn got=%b exp=0", turn); end
      step(2'b00, 2'b01);
      checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL single_rel_gnt got=%b exp=00", gnt); end
      step(2'b00, 2'b00);
      checks++; if (turn !== 1'b1) begin failures++; $display("FAIL single_rel_turn got=%b exp=1", turn); end
   endtask

   task automatic test_contention();
      do_reset();
      step(2'b11, 2'b00);
      checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL cont_gnt_t1 got=%b exp=00", gnt); end
      step(2'b11, 2'b00);
      checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL cont_gnt_t2 got=%b exp=01", gnt); end
      step(2'b11, 2'b01);
      checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL cont_rel_gnt got=%b exp=00", gnt); end
      step(2'b10, 2'b00);
      checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL cont_dead_gnt got=%b exp=00", gnt); end
      checks++; if (turn !== 1'b1) begin failures++; $display("FAIL cont_turn got=%b exp=1", turn); end
      checks++; if (wc1 !== 3'd4) begin failures++; $display("FAIL cont_wc1 got=%0d exp=4", wc1); end
      step(2'b10, 2'b00);
      checks++; if (gnt !== 2'b10) begin failures++; $display("FAIL cont_gnt1 got=%b exp=10", gnt); end
      checks++; if (wc1 !== 3'd0) begin failures++; $display("FAIL cont_wc1_clr got=%0d exp=0", wc1); end
   endtask

   task automatic test_saturation();
      int e;
      do_reset();
      step(2'b10, 2'b00);
      step(2'b10, 2'b00);
      for (int k = 1; k <= 9; k++) begin
         step(2'b11, 2'b00);
         e = (k > WMAX) ? WMAX : k;
         checks++; if (int'(wc0) != e) begin failures++; $display("FAIL sat_wc0 k=%0d got=%0d exp=%0d", k, wc0, e); end
         checks++; if (gnt !== 2'b10) begin failures++; $display("FAIL sat_gnt k=%0d got=%b exp=10", k, gnt); end
      end
   endtask

   task automatic test_abort();
      do_reset();
      step(2'b01, 2'b00);
      step(2'b01, 2'b00);
      step(2'b00, 2'b01);
      step(2'b10, 2'b00);
      step(2'b10, 2'b00);
      checks++; if (gnt !== 2'b10 || turn !== 1'b1) begin failures++; $display("FAIL abort_setup gnt=%b turn=%b exp=10/1", gnt, turn); end
      step(2'b11, 2'b00);
      checks++; if (wc0 !== 3'd1) begin failures++; $display("FAIL abort_wc0_req got=%0d exp=1", wc0); end
      step(2'b10, 2'b00);
      checks++; if (wc0 !== 3'd0) begin failures++; $display("FAIL abort_wc0 got=%0d exp=0", wc0); end
      checks++; if (turn !== 1'b1) begin failures++; $display("FAIL abort_turn got=%b exp=1", turn); end
      step(2'b10, 2'b00);
      checks++; if (gnt !== 2'b10) begin failures++; $display("FAIL abort_gnt got=%b exp=10", gnt); end
      step(2'b00, 2'b10);
      step(2'b00, 2'b00);
      step(2'b00, 2'b00);
      checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL abort_nogrant got=%b exp=00", gnt); end
      checks++; if (turn !== 1'b0) begin failures++; $display("FAIL abort_turn_after got=%b exp=0", turn); end
   endtask

   task automatic test_revoke();
      do_reset();
      step(2'b01, 2'b00);
      step(2'b01, 2'b00);
`ifdef LOCK_REVOKE_EN
      for (int k = 2; k <= HOLD_LIMIT; k++) begin
         step(2'b01, 2'b00);
         checks++; if (gnt !== 2'b01 || revoked !== 2'b00) begin failures++; $display("FAIL revoke_hold k=%0d gnt=%b rev=%b exp=01/00", k, gnt, revoked); end
      end
      step(2'b01, 2'b00);
      checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL revoke_gnt got=%b exp=00", gnt); end
      checks++; if (revoked !== 2'b01) begin failures++; $display("FAIL revoke_pulse got=%b exp=01", revoked); end
      step(2'b00, 2'b00);
      checks++; if (revoked !== 2'b00) begin failures++; $display("FAIL revoke_pulse_end got=%b exp=00", revoked); end
      checks++; if (turn !== 1'b1) begin failures++; $display("FAIL revoke_turn got=%b exp=1", turn); end
`else
      for (int k = 2; k <= HOLD_LIMIT + 3; k++) begin
         step(2'b01, 2'b00);
         checks++; if (gnt !== 2'b01 || revoked !== 2'b00) begin failures++; $display("FAIL norevoke_hold k=%0d gnt=%b rev=%b exp=01/00", k, gnt, revoked); end
      end
`endif
   endtask

   task automatic test_random();
      logic [1:0] rq, rl;
      do_reset();
      for (int n = 0; n < 1000; n++) begin
         rst = ($urandom_range(0, 199) == 0);
         rq = 2'($urandom);
         rl = ($urandom_range(0, 7) == 0) ? 2'b11 : ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
         step(rq, rl);
         checks++; if (gnt !== exp_gnt()) begin failures++; $display("FAIL rand_gnt n=%0d got=%b exp=%b", n, gnt, exp_gnt()); end
         checks++; if (gnt === 2'b11) begin failures++; $display("FAIL rand_mutex n=%0d got=%b exp=not 11", n, gnt); end
         checks++; if (turn !== m_turn) begin failures++; $display("FAIL rand_turn n=%0d got=%b exp=%b", n, turn, m_turn); end
         checks++; if (int'(wc0) != m_wait[0]) begin failures++; $display("FAIL rand_wc0 n=%0d got=%0d exp=%0d", n, wc0, m_wait[0]); end
         checks++; if (int'(wc1) != m_wait[1]) begin failures++; $display("FAIL rand_wc1 n=%0d got=%0d exp=%0d", n, wc1, m_wait[1]); end
         checks++; if (revoked !== m_revk) begin failures++; $display("FAIL rand_revoked n=%0d got=%b exp=%b", n, revoked, m_revk); end
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_saturation();
      test_abort();
      test_revoke();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
